// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
package uart_pkg;

    localparam int UART_OSR       = 16;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync2.sv
// Generic two-flop synchroniser for asynchronous single-bit inputs.
// Reset value is a parameter so idle-high lines do not see a false edge out of reset.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ff_q <= {2{RESET_VAL}};
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with valid/ready byte output, frame-error and sticky overrun flags.
// Define UART_RX_PARITY_EN to add a parity bit, the PARITY_ODD parameter and rx_parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OSR       = UART_OSR,
    parameter int DATA_BITS = UART_DATA_BITS
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 rx_parity_err
`endif
);

    localparam int TW = $clog2(OSR);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OSR / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OSR - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 complete;
    logic                 accept;
    logic                 drop;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 rx_frame_err_q;
    logic                 rx_overrun_q;

`ifdef UART_RX_PARITY_EN
    logic                 par_err_q, par_err_d;
    logic                 rx_parity_err_q;
`endif

    sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .d_i   (rx_in),
        .q_o   (rx_s)
    );

    // Frame sequencer: only moves on oversample ticks, sampling each bit at its centre.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        complete   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d  = par_err_q;
`endif
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    if (tick_cnt_q == HALF_LAST) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        par_err_d  = ((^shift_q) ^ rx_s) != PARITY_ODD;
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        complete   = 1'b1;
                        state_d    = rx_s ? IDLE : WAIT_HIGH;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
`ifdef UART_RX_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    assign accept = rx_valid_q && rx_ready;
    assign drop   = complete && rx_valid_q && !rx_ready;

    // A new byte may replace one being accepted this cycle; otherwise it is dropped and flagged.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            rx_frame_err_q  <= 1'b0;
            rx_overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err_q <= 1'b0;
`endif
        end else begin
            if (complete && (!rx_valid_q || rx_ready)) begin
                rx_data_q       <= shift_q;
                rx_frame_err_q  <= ~rx_s;
                rx_valid_q      <= 1'b1;
`ifdef UART_RX_PARITY_EN
                rx_parity_err_q <= par_err_q;
`endif
            end else if (accept) begin
                rx_valid_q <= 1'b0;
            end
            if (drop) begin
                rx_overrun_q <= 1'b1;
            end else if (accept) begin
                rx_overrun_q <= 1'b0;
            end
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_overrun   = rx_overrun_q;
    assign rx_busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = rx_parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed corner cases, a vector table and random frames
// compared against a frame-level reference model. Honours UART_RX_PARITY_EN like the design.
module tb_uart_rx;

    localparam int OSR = 16;
    localparam int DB  = 8;

    logic          clk_in   = 1'b0;
    logic          rst_n    = 1'b0;
    logic          tick     = 1'b0;
    logic          rx_in    = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_frame_err;
    logic          rx_overrun;
    logic          rx_busy;
`ifdef UART_RX_PARITY_EN
    logic          rx_parity_err;
`endif

    int total   = 0;
    int bad     = 0;
    int tickDiv = 4;
    int tickCnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } rxByte_t;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        logic [7:0] expData;
        logic       expFerr;
    } vec_t;

    rxByte_t gotQ[$];
    rxByte_t expQ[$];
    vec_t    vecs[6];

    uart_rx #(
        .OSR      (OSR),
        .DATA_BITS(DB)
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .tick         (tick),
        .rx_in        (rx_in),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
`ifdef UART_RX_PARITY_EN
        ,
        .rx_parity_err(rx_parity_err)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Oversample strobe: one clock wide, every tickDiv clocks.
    always @(negedge clk_in) begin
        if (tickCnt >= tickDiv - 1) begin
            tickCnt = 0;
            tick    = 1'b1;
        end else begin
            tickCnt = tickCnt + 1;
            tick    = 1'b0;
        end
    end

    // Record every byte actually handed over on the valid/ready interface.
    always @(negedge clk_in) begin : monitor
        rxByte_t b;
        if (rx_valid && rx_ready) begin
            b.data = rx_data;
            b.ferr = rx_frame_err;
`ifdef UART_RX_PARITY_EN
            b.perr = rx_parity_err;
`else
            b.perr = 1'b0;
`endif
            gotQ.push_back(b);
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #3;
    endtask

    task automatic lineBits(input logic v, input int nBits);
        rx_in = v;
        step(nBits * OSR * tickDiv);
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic stopBit, input logic parBit);
        lineBits(1'b0, 1);
        for (int i = 0; i < 8; i++) lineBits(d[i], 1);
`ifdef UART_RX_PARITY_EN
        lineBits(parBit, 1);
`endif
        lineBits(stopBit, 1);
    endtask

    task automatic waitValid(input string name, input int maxCyc);
        int n = 0;
        while (!rx_valid && n < maxCyc) begin
            step(1);
            n++;
        end
        checkOutput(name, rx_valid, 1);
    endtask

    task automatic acceptByte();
        rx_ready = 1'b1;
        step(1);
        checkOutput("valid drops after accept", rx_valid, 0);
        rx_ready = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        rx_ready = 1'b0;
        sendFrame(v.data, v.stopBit, ^v.data);
        lineBits(1'b1, 2);
        waitValid("table valid", 500);
        checkOutput("table data", rx_data, v.expData);
        checkOutput("table ferr", rx_frame_err, v.expFerr);
`ifdef UART_RX_PARITY_EN
        checkOutput("table perr", rx_parity_err, 0);
`endif
        acceptByte();
    endtask

    initial begin
        logic       sawBusy;
        logic [7:0] d;
        logic       stopBit;
        logic       parBit;
        rxByte_t    e;

        vecs[0] = '{8'h00, 1'b1, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
        vecs[2] = '{8'h80, 1'b0, 8'h80, 1'b1};
        vecs[3] = '{8'h01, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h5A, 1'b0, 8'h5A, 1'b1};
        vecs[5] = '{8'hC3, 1'b1, 8'hC3, 1'b0};

        step(3);
        checkOutput("reset data", rx_data, 0);
        checkOutput("reset valid", rx_valid, 0);
        checkOutput("reset ferr", rx_frame_err, 0);
        checkOutput("reset overrun", rx_overrun, 0);
        checkOutput("reset busy", rx_busy, 0);
        rst_n = 1'b1;
        step(5);

        // Basic frame at the slow tick rate.
        tickDiv = 39;
        lineBits(1'b1, 2);
        sendFrame(8'hA5, 1'b1, ^8'hA5);
        waitValid("A5 valid", 2000);
        checkOutput("A5 data", rx_data, 8'hA5);
        checkOutput("A5 ferr", rx_frame_err, 0);
        acceptByte();

        // Short low glitch must be rejected during START.
        tickDiv = 4;
        lineBits(1'b1, 2);
        sawBusy = 1'b0;
        rx_in = 1'b0;
        for (int i = 0; i < 5 * tickDiv; i++) begin
            step(1);
            if (rx_busy) sawBusy = 1'b1;
        end
        rx_in = 1'b1;
        for (int i = 0; i < 16 * tickDiv; i++) begin
            step(1);
            if (rx_busy) sawBusy = 1'b1;
        end
        checkOutput("glitch busy seen", sawBusy, 1);
        checkOutput("glitch back idle", rx_busy, 0);
        checkOutput("glitch no byte", rx_valid, 0);

        // Break: bad stop bit then line held low gives exactly one errored byte.
        rx_ready = 1'b1;
        gotQ.delete();
        sendFrame(8'h3C, 1'b0, ^8'h3C);
        lineBits(1'b0, 3);
        checkOutput("break byte count", gotQ.size(), 1);
        if (gotQ.size() >= 1) begin
            checkOutput("break data", gotQ[0].data, 8'h3C);
            checkOutput("break ferr", gotQ[0].ferr, 1);
        end
        checkOutput("break busy held", rx_busy, 1);
        lineBits(1'b1, 2);
        checkOutput("break released idle", rx_busy, 0);
        checkOutput("break no repeat", gotQ.size(), 1);
        sendFrame(8'h96, 1'b1, ^8'h96);
        lineBits(1'b1, 1);
        checkOutput("after break count", gotQ.size(), 2);
        if (gotQ.size() >= 2) begin
            checkOutput("after break data", gotQ[1].data, 8'h96);
            checkOutput("after break ferr", gotQ[1].ferr, 0);
        end

        // Back-to-back bytes without ready: second is dropped, overrun sticks.
        rx_ready = 1'b0;
        step(2);
        sendFrame(8'h11, 1'b1, ^8'h11);
        sendFrame(8'h22, 1'b1, ^8'h22);
        lineBits(1'b1, 1);
        checkOutput("overrun valid", rx_valid, 1);
        checkOutput("overrun data kept", rx_data, 8'h11);
        checkOutput("overrun set", rx_overrun, 1);
        rx_ready = 1'b1;
        step(1);
        checkOutput("overrun cleared", rx_overrun, 0);
        checkOutput("overrun valid cleared", rx_valid, 0);
        rx_ready = 1'b0;

        // Reset in the middle of a frame while a flagged byte is pending.
        sendFrame(8'hC3, 1'b0, ^8'hC3);
        lineBits(1'b1, 1);
        sendFrame(8'h3C, 1'b1, ^8'h3C);
        lineBits(1'b1, 1);
        checkOutput("pre-reset ferr", rx_frame_err, 1);
        checkOutput("pre-reset overrun", rx_overrun, 1);
        lineBits(1'b0, 1);
        lineBits(1'b1, 4);
        step(OSR * tickDiv / 2);
        checkOutput("pre-reset busy", rx_busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset data", rx_data, 0);
        checkOutput("midreset valid", rx_valid, 0);
        checkOutput("midreset ferr", rx_frame_err, 0);
        checkOutput("midreset overrun", rx_overrun, 0);
        checkOutput("midreset busy", rx_busy, 0);
        step(3);
        rst_n = 1'b1;
        lineBits(1'b1, 2);
        sendFrame(8'h5A, 1'b1, ^8'h5A);
        waitValid("5A valid", 500);
        checkOutput("5A data", rx_data, 8'h5A);
        checkOutput("5A ferr", rx_frame_err, 0);
        acceptByte();

`ifdef UART_RX_PARITY_EN
        lineBits(1'b1, 2);
        sendFrame(8'h07, 1'b1, 1'b1);
        lineBits(1'b1, 1);
        waitValid("par good valid", 500);
        checkOutput("par good perr", rx_parity_err, 0);
        acceptByte();
        sendFrame(8'h07, 1'b1, 1'b0);
        lineBits(1'b1, 1);
        waitValid("par bad valid", 500);
        checkOutput("par bad perr", rx_parity_err, 1);
        acceptByte();
`endif

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Random frames against the frame-level model, consumer always ready.
        tickDiv = 3;
        lineBits(1'b1, 2);
        rx_ready = 1'b1;
        gotQ.delete();
        expQ.delete();
        for (int i = 0; i < 24; i++) begin
            d       = 8'($urandom);
            stopBit = ($urandom_range(0, 5) != 0);
            parBit  = 1'($urandom);
            sendFrame(d, stopBit, parBit);
            lineBits(1'b1, 2);
            e.data = d;
            e.ferr = ~stopBit;
`ifdef UART_RX_PARITY_EN
            e.perr = (($countones(d) + int'(parBit)) % 2) != 0;
`else
            e.perr = 1'b0;
`endif
            expQ.push_back(e);
        end
        checkOutput("random byte count", gotQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checkOutput($sformatf("random byte %0d", i),
                        {gotQ[i].perr, gotQ[i].ferr, gotQ[i].data},
                        {expQ[i].perr, expQ[i].ferr, expQ[i].data});
        end
        checkOutput("random no overrun", rx_overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
